// File: rtl/vga_rect_fill_master_if.sv
// Shared-bus request/grant and address lines between a bus master and the arbiter/peripheral side.
//   BUS_REQ  : master -> arbiter, bus request
//   BUS_GNT  : arbiter -> master, bus grant
//   BUS_ADDR : master -> peripherals, bus address
interface vga_rect_fill_master_if;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic [7:0] BUS_ADDR;

  modport master (output BUS_REQ, output BUS_ADDR, input BUS_GNT);
  modport slave  (input BUS_REQ, input BUS_ADDR, output BUS_GNT);
endinterface

// File: rtl/vga_rect_fill_master.sv
// Filled-rectangle drawing bus master for the VGA frame buffer.
// Takes a corner-pair command. Once it is granted the shared bus, it writes every pixel
// as an address/data sequence (Y at ADDR_Y, X at ADDR_X, pixel at ADDR_PIX), with an idle-address gap after each pixel.
//   CLK, RESET      : clock, synchronous active-high reset
//   START           : command strobe (sampled only when idle)
//   X0/Y0, X1/Y1    : rectangle corners, any order
//   PIXEL           : fill value
//   BUSY/DONE/ERR   : status; DONE and ERR are one-cycle pulses
//   bus             : BUS_REQ / BUS_GNT / BUS_ADDR
//   BUS_DATA        : bus data, driven only during coordinate/pixel writes
module vga_rect_fill_master #(
  parameter logic [7:0]  ADDR_X    = 8'hB0,
  parameter logic [7:0]  ADDR_Y    = 8'hB1,
  parameter logic [7:0]  ADDR_PIX  = 8'hB2,
  parameter logic [7:0]  ADDR_IDLE = 8'hFF,
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned Y_MAX     = 119
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic [7:0]                    X0,
  input  logic [6:0]                    Y0,
  input  logic [7:0]                    X1,
  input  logic [6:0]                    Y1,
  input  logic                          PIXEL,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          ERR,
  vga_rect_fill_master_if.master        bus,
  inout  wire  [7:0]                    BUS_DATA
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned DW = 8;
  localparam logic [XW-1:0] X_LIM = XW'(X_MAX);
  localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SET_Y, S_SET_X, S_WR_PIX, S_GAP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   xl_q, xh_q, cx_q, xl_d, xh_d, cx_d;
  logic [YW-1:0]   yl_q, yh_q, cy_q, yl_d, yh_d, cy_d;
  logic            pix_q, pix_d;
  logic            busy_d, done_d, err_d, req_d, drv_q, drv_d;
  logic [DW-1:0]   addr_d, data_q, data_d;

  // Normalised corners of the incoming command
  logic [XW-1:0]   x_lo_c, x_hi_c;
  logic [YW-1:0]   y_lo_c, y_hi_c;
  logic            last_col_c, last_px_c;
  logic [XW-1:0]   nxt_cx_c;
  logic [YW-1:0]   nxt_cy_c;

  assign x_lo_c = (X0 < X1) ? X0 : X1;
  assign x_hi_c = (X0 < X1) ? X1 : X0;
  assign y_lo_c = (Y0 < Y1) ? Y0 : Y1;
  assign y_hi_c = (Y0 < Y1) ? Y1 : Y0;

  // Raster-order successor of the current pixel
  assign last_col_c = (cx_q == xh_q);
  assign last_px_c  = last_col_c && (cy_q == yh_q);
  assign nxt_cx_c   = last_col_c ? xl_q : cx_q + XW'(1);
  assign nxt_cy_c   = last_col_c ? cy_q + YW'(1) : cy_q;

  assign BUS_DATA = drv_q ? data_q : {DW{1'bz}};

  // Next-state logic; bus/status outputs are decoded from the next state and registered
  always_comb begin
    state_d = state_q;
    xl_d    = xl_q;
    xh_d    = xh_q;
    yl_d    = yl_q;
    yh_d    = yh_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    pix_d   = pix_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          if ((x_hi_c > X_LIM) || (y_hi_c > Y_LIM)) begin
            err_d = 1'b1;
          end else begin
            xl_d    = x_lo_c;
            xh_d    = x_hi_c;
            yl_d    = y_lo_c;
            yh_d    = y_hi_c;
            cx_d    = x_lo_c;
            cy_d    = y_lo_c;
            pix_d   = PIXEL;
            state_d = S_REQ;
          end
        end
      end
      S_REQ:    if (bus.BUS_GNT) state_d = S_SET_Y;
      S_SET_Y:  state_d = S_SET_X;
      S_SET_X:  state_d = S_WR_PIX;
      S_WR_PIX: state_d = S_GAP;
      S_GAP: begin
        // Coordinates only move here, after the idle address has cleared the write enable
        if (last_px_c) begin
          state_d = S_DONE;
        end else begin
          cx_d = nxt_cx_c;
          cy_d = nxt_cy_c;
          if (!bus.BUS_GNT)   state_d = S_REQ;
          else if (last_col_c) state_d = S_SET_Y;
          else                 state_d = S_SET_X;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    req_d  = (state_d == S_REQ) || (state_d == S_SET_Y) || (state_d == S_SET_X) ||
             (state_d == S_WR_PIX) || (state_d == S_GAP);
    addr_d = ADDR_IDLE;
    drv_d  = 1'b0;
    data_d = '0;
    case (state_d)
      S_SET_Y: begin
        addr_d = ADDR_Y;
        drv_d  = 1'b1;
        data_d = {1'b0, cy_d};
      end
      S_SET_X: begin
        addr_d = ADDR_X;
        drv_d  = 1'b1;
        data_d = cx_d;
      end
      S_WR_PIX: begin
        addr_d = ADDR_PIX;
        drv_d  = 1'b1;
        data_d = {7'b0, pix_d};
      end
      default: ;
    endcase
  end

  // State, coordinate and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      xl_q         <= '0;
      xh_q         <= '0;
      yl_q         <= '0;
      yh_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      pix_q        <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
      bus.BUS_REQ  <= 1'b0;
      bus.BUS_ADDR <= ADDR_IDLE;
      drv_q        <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      xl_q         <= xl_d;
      xh_q         <= xh_d;
      yl_q         <= yl_d;
      yh_q         <= yh_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      pix_q        <= pix_d;
      BUSY         <= busy_d;
      DONE         <= done_d;
      ERR          <= err_d;
      bus.BUS_REQ  <= req_d;
      bus.BUS_ADDR <= addr_d;
      drv_q        <= drv_d;
      data_q       <= data_d;
    end
  end

endmodule
